// File: rtl/matrix_print_ctrl.sv
// matrix_print_ctrl: walks an m x n matrix row-major, reads each element and issues one sender request
// per element, then a blank line. Define MATRIX_PRINT_ID_EN to print "m" alone on a line first.
module matrix_print_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int MAX_DIM = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        rows,
  input  logic [2:0]        cols,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              snd_start,
  output logic [7:0]        snd_data,
  output logic              snd_last_col,
  output logic              snd_newline,
  output logic              snd_id,
  input  logic              snd_done,
  output logic              busy,
  output logic              done,
  output logic              err_dim
);

  typedef enum logic [3:0] {
    S_IDLE, S_ID_REQ, S_ID_WAIT, S_RD_ADDR, S_RD_DATA,
    S_EL_REQ, S_EL_WAIT, S_NL_REQ, S_NL_WAIT, S_FIN
  } state_t;

  localparam logic [3:0] MAX_D = 4'(MAX_DIM);

  state_t            state, state_nxt;
  logic [2:0]        rows_q, cols_q, r_cnt, c_cnt;
  logic [ADDR_W-1:0] ptr;
  logic              err_q;
  logic              dim_bad, dim_empty, col_end, last_el;

  assign dim_bad   = ({1'b0, rows} > MAX_D) || ({1'b0, cols} > MAX_D);
  assign dim_empty = (rows == 3'd0) || (cols == 3'd0);
  assign col_end   = (c_cnt == cols_q - 3'd1);
  assign last_el   = col_end && (r_cnt == rows_q - 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Sender handshake: a request (snd_start or snd_newline) is a 1-cycle pulse; the sender answers
  // with a 1-cycle snd_done. Only one request is ever outstanding, and snd_done is honoured only
  // in a *_WAIT state, so stray completions are harmless.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (dim_bad || dim_empty) state_nxt = S_FIN;
`ifdef MATRIX_PRINT_ID_EN
          else                      state_nxt = S_ID_REQ;
`else
          else                      state_nxt = S_RD_ADDR;
`endif
        end
      end
`ifdef MATRIX_PRINT_ID_EN
      S_ID_REQ:  state_nxt = S_ID_WAIT;
      S_ID_WAIT: if (snd_done) state_nxt = S_RD_ADDR;
`endif
      S_RD_ADDR: state_nxt = S_RD_DATA;
      S_RD_DATA: state_nxt = S_EL_REQ;
      S_EL_REQ:  state_nxt = S_EL_WAIT;
      S_EL_WAIT: if (snd_done) state_nxt = last_el ? S_NL_REQ : S_RD_ADDR;
      S_NL_REQ:  state_nxt = S_NL_WAIT;
      S_NL_WAIT: if (snd_done) state_nxt = S_FIN;
      S_FIN:     state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Job context is captured once at acceptance; the live inputs are ignored afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q   <= '0;
      cols_q   <= '0;
      r_cnt    <= '0;
      c_cnt    <= '0;
      ptr      <= '0;
      err_q    <= 1'b0;
      snd_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            rows_q <= rows;
            cols_q <= cols;
            ptr    <= base_addr;
            r_cnt  <= '0;
            c_cnt  <= '0;
            err_q  <= dim_bad;
`ifdef MATRIX_PRINT_ID_EN
            snd_data <= {5'b0, rows};
`endif
          end
        end
        S_RD_DATA: snd_data <= mem_rdata;
        S_EL_WAIT: begin
          if (snd_done) begin
            ptr <= ptr + 1'b1;
            if (col_end) begin
              c_cnt <= '0;
              r_cnt <= r_cnt + 3'd1;
            end else begin
              c_cnt <= c_cnt + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_rd_en    = 1'b0;
    mem_addr     = '0;
    snd_start    = 1'b0;
    snd_last_col = 1'b0;
    snd_newline  = 1'b0;
    snd_id       = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    err_dim      = 1'b0;
    case (state)
      S_IDLE: ;
`ifdef MATRIX_PRINT_ID_EN
      S_ID_REQ: begin
        snd_start    = 1'b1;
        snd_id       = 1'b1;
        snd_last_col = 1'b1;
        busy         = 1'b1;
      end
`endif
      S_RD_ADDR: begin
        mem_rd_en = 1'b1;
        mem_addr  = ptr;
        busy      = 1'b1;
      end
      S_EL_REQ: begin
        snd_start    = 1'b1;
        snd_last_col = col_end;
        busy         = 1'b1;
      end
      S_NL_REQ: begin
        snd_newline = 1'b1;
        busy        = 1'b1;
      end
      S_FIN: begin
        done    = 1'b1;
        err_dim = err_q;
      end
      default: busy = 1'b1;
    endcase
  end

endmodule
